mram_arbiter: RTL

Two-port arbiter and access sequencer for the 32 KiB monitor/main RAM of the MZ-80A core. It shares the RAM's single `addr/din/dout/en/we` port between the Z80 CPU bus and a DMA requester (tape/QuickLoad loader). It serialises their transactions, holds the RAM strobes stable for a fixed number of clocks, and returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mram_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mram_arbiter.sv
// mram_arbiter: CPU/DMA arbiter and fixed-length access sequencer for the 32 KiB MZ-80A RAM.
// Define MRAM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module mram_arbiter #(
  parameter int ACC_CYC = 2,
  parameter int AW      = 15,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_en,
  output logic          ram_we,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
  localparam logic [3:0] CNT_LD = 4'(ACC_CYC - 1);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          gnt, gnt_nx;  // granted port: 0 = CPU, 1 = DMA
  logic          win, any_req;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] din_nx, cpu_rdata_nx, dma_rdata_nx;
  logic          en_nx, we_nx, cpu_ack_nx, dma_ack_nx, busy_nx;

  assign any_req = cpu_req | dma_req;

`ifdef MRAM_ARB_RR_EN
  logic last;  // last granted port, same encoding as gnt

  assign win = dma_req & (~cpu_req | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (state == IDLE && any_req)
      last <= win;
  end
`else
  assign win = dma_req & ~cpu_req;
`endif

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    gnt_nx       = gnt;
    addr_nx      = ram_addr;
    din_nx       = ram_din;
    en_nx        = ram_en;
    we_nx        = ram_we;
    cpu_rdata_nx = cpu_rdata;
    dma_rdata_nx = dma_rdata;
    cpu_ack_nx   = 1'b0;
    dma_ack_nx   = 1'b0;
    busy_nx      = busy;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = ACCESS;
          gnt_nx   = win;
          addr_nx  = win ? dma_addr  : cpu_addr;
          din_nx   = win ? dma_wdata : cpu_wdata;
          we_nx    = win ? dma_we    : cpu_we;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = CNT_LD;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (!ram_we) begin
            if (gnt) dma_rdata_nx = ram_dout;
            else     cpu_rdata_nx = ram_dout;
          end
          en_nx      = 1'b0;
          we_nx      = 1'b0;
          cpu_ack_nx = ~gnt;
          dma_ack_nx = gnt;
          state_nx   = ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        we_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt       <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      ram_addr  <= addr_nx;
      ram_din   <= din_nx;
      ram_en    <= en_nx;
      ram_we    <= we_nx;
      cpu_rdata <= cpu_rdata_nx;
      dma_rdata <= dma_rdata_nx;
      cpu_ack   <= cpu_ack_nx;
      dma_ack   <= dma_ack_nx;
      busy      <= busy_nx;
    end
  end

endmodule
